// File: rtl/mem_access_unit.sv
// Load/store initiator between the MEM stage and a word-wide data memory.
// Lanes that the memory's low-lane write masks cannot reach are stored by read-modify-write.
module mem_access_unit #(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        is_store,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_ce,
  output logic        mem_we,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic [3:0]  mem_rmask,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WRITE, S_RMW_RD, S_RMW_WR, S_RESP
  } state_t;

  state_t      r_state;
  logic [1:0]  r_lat_size;
  logic        r_lat_sext;
  logic [31:0] r_lat_addr;
  logic [31:0] r_lat_wdata;
  logic        r_done;
  logic        r_err;
  logic [31:0] r_rdata;
  logic        r_mem_ce;
  logic        r_mem_we;
  logic        r_mem_rd;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_wmask;
  logic [3:0]  r_mem_rmask;

  logic        w_in_byte;
  logic        w_in_half;
  logic        w_in_word;
  logic        w_misaligned;
  logic        w_in_rmw;
  logic [3:0]  w_in_wmask;
  logic [7:0]  w_lane_byte;
  logic [15:0] w_lane_half;
  logic [31:0] w_load_data;
  logic [31:0] w_merged;

  // Request decode works on the live inputs, since dispatch happens on the accepting edge.
  assign w_in_byte    = (size == 2'b00);
  assign w_in_half    = (size == 2'b01);
  assign w_in_word    = size[1];
  assign w_misaligned = ALIGN_CHECK &&
                        ((w_in_half && addr[0]) || (w_in_word && (addr[1:0] != 2'b00)));
  assign w_in_rmw     = (w_in_byte && (addr[1:0] != 2'b00)) || (w_in_half && addr[1]);
  assign w_in_wmask   = w_in_byte ? 4'b0001 : (w_in_half ? 4'b0011 : 4'b1111);

  always_comb begin
    w_lane_byte = mem_rdata[7:0];
    case (r_lat_addr[1:0])
      2'b01:   w_lane_byte = mem_rdata[15:8];
      2'b10:   w_lane_byte = mem_rdata[23:16];
      2'b11:   w_lane_byte = mem_rdata[31:24];
      default: w_lane_byte = mem_rdata[7:0];
    endcase
    w_lane_half = r_lat_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    if (r_lat_size == 2'b00)
      w_load_data = {{24{r_lat_sext & w_lane_byte[7]}}, w_lane_byte};
    else if (r_lat_size == 2'b01)
      w_load_data = {{16{r_lat_sext & w_lane_half[15]}}, w_lane_half};
    else
      w_load_data = mem_rdata;

    // Only byte at a nonzero offset or upper half ever reach the merge path.
    w_merged = mem_rdata;
    if (r_lat_size == 2'b00) begin
      case (r_lat_addr[1:0])
        2'b01:   w_merged[15:8]  = r_lat_wdata[7:0];
        2'b10:   w_merged[23:16] = r_lat_wdata[7:0];
        2'b11:   w_merged[31:24] = r_lat_wdata[7:0];
        default: w_merged[7:0]   = r_lat_wdata[7:0];
      endcase
    end else begin
      w_merged[31:16] = r_lat_wdata[15:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_lat_size  <= 2'b00;
      r_lat_sext  <= 1'b0;
      r_lat_addr  <= '0;
      r_lat_wdata <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_mem_ce    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_mem_wdata <= '0;
      r_mem_wmask <= 4'b0000;
      r_mem_rmask <= 4'b0000;
    end else begin
      // NOTE: these defaults make every strobe a one-cycle pulse; with non-blocking
      // assignment the later assignment in the case below overrides them.
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_mem_ce    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_mem_wdata <= '0;
      r_mem_wmask <= 4'b0000;
      r_mem_rmask <= 4'b0000;

      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_lat_size  <= size;
            r_lat_sext  <= sext;
            r_lat_addr  <= addr;
            r_lat_wdata <= wdata;
            if (w_misaligned) begin
              r_state <= S_RESP;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else if (!is_store || w_in_rmw) begin
              r_state     <= is_store ? S_RMW_RD : S_LOAD;
              r_mem_ce    <= 1'b1;
              r_mem_rd    <= 1'b1;
              r_mem_rmask <= 4'b1111;
            end else begin
              r_state     <= S_WRITE;
              r_mem_ce    <= 1'b1;
              r_mem_we    <= 1'b1;
              r_mem_wmask <= w_in_wmask;
              r_mem_wdata <= wdata;
            end
          end
        end
        S_LOAD: begin
          r_rdata <= w_load_data;
          r_state <= S_RESP;
          r_done  <= 1'b1;
        end
        S_RMW_RD: begin
          r_state     <= S_RMW_WR;
          r_mem_ce    <= 1'b1;
          r_mem_we    <= 1'b1;
          r_mem_wmask <= 4'b1111;
          r_mem_wdata <= w_merged;
        end
        S_WRITE, S_RMW_WR: begin
          r_state <= S_RESP;
          r_done  <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign err       = r_err;
  assign rdata     = r_rdata;
  assign mem_ce    = r_mem_ce;
  assign mem_we    = r_mem_we;
  assign mem_rd    = r_mem_rd;
  assign mem_addr  = {r_lat_addr[31:2], 2'b00};
  assign mem_wdata = r_mem_wdata;
  assign mem_wmask = r_mem_wmask;
  assign mem_rmask = r_mem_rmask;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: two instances (alignment check on/off),
// each with a small behavioural memory honouring the low-lane write masks.
module tb_mem_access_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, mem_init, sel;
  logic        req0, req1, is_store, sext;
  logic [1:0]  size;
  logic [31:0] addr, wdata;

  logic        busy0, done0, err0, ce0, we0, rd0;
  logic        busy1, done1, err1, ce1, we1, rd1;
  logic [31:0] rdata0, maddr0, mwd0, mrd0;
  logic [31:0] rdata1, maddr1, mwd1, mrd1;
  logic [3:0]  wm0, rm0, wm1, rm1;

  mem_access_unit #(.ALIGN_CHECK(1'b1)) dut (
    .clk(clk), .rst(rst), .req(req0), .is_store(is_store), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .busy(busy0), .done(done0), .err(err0), .rdata(rdata0),
    .mem_ce(ce0), .mem_we(we0), .mem_rd(rd0), .mem_addr(maddr0), .mem_wdata(mwd0),
    .mem_wmask(wm0), .mem_rmask(rm0), .mem_rdata(mrd0)
  );

  mem_access_unit #(.ALIGN_CHECK(1'b0)) dut_na (
    .clk(clk), .rst(rst), .req(req1), .is_store(is_store), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .busy(busy1), .done(done1), .err(err1), .rdata(rdata1),
    .mem_ce(ce1), .mem_we(we1), .mem_rd(rd1), .mem_addr(maddr1), .mem_wdata(mwd1),
    .mem_wmask(wm1), .mem_rmask(rm1), .mem_rdata(mrd1)
  );

  // Observed view of whichever instance the current vector targets.
  logic        o_busy, o_done, o_err, o_ce, o_we, o_rd;
  logic [31:0] o_rdata, o_wdata, o_addr;
  logic [3:0]  o_wmask, o_rmask;
  assign o_busy  = sel ? busy1 : busy0;
  assign o_done  = sel ? done1 : done0;
  assign o_err   = sel ? err1 : err0;
  assign o_ce    = sel ? ce1 : ce0;
  assign o_we    = sel ? we1 : we0;
  assign o_rd    = sel ? rd1 : rd0;
  assign o_rdata = sel ? rdata1 : rdata0;
  assign o_wdata = sel ? mwd1 : mwd0;
  assign o_addr  = sel ? maddr1 : maddr0;
  assign o_wmask = sel ? wm1 : wm0;
  assign o_rmask = sel ? rm1 : rm0;

  logic [31:0] mem0 [16];
  logic [31:0] mem1 [16];
  assign mrd0 = mem0[maddr0[5:2]];
  assign mrd1 = mem1[maddr1[5:2]];

  function automatic logic [31:0] mem_write(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [3:0] wm);
    case (wm)
      4'b0001: mem_write = {old[31:8], wd[7:0]};
      4'b0011: mem_write = {old[31:16], wd[15:0]};
      default: mem_write = wd;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) begin
        mem0[i] <= '0;
        mem1[i] <= '0;
      end
      mem0[4] <= 32'h8899AABB;
      mem1[4] <= 32'h8899AABB;
    end else begin
      if (ce0 && we0) mem0[maddr0[5:2]] <= mem_write(mem0[maddr0[5:2]], mwd0, wm0);
      if (ce1 && we1) mem1[maddr1[5:2]] <= mem_write(mem1[maddr1[5:2]], mwd1, wm1);
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        sel;
    logic        st;
    logic [1:0]  sz;
    logic        sx;
    logic [31:0] addr;
    logic [31:0] wd;
    int          lat;
    logic        err;
    logic [31:0] rdata;
    logic        we;
    logic [3:0]  wm;
    logic [31:0] wdo;
  } vec_t;

  int          obs_lat;
  logic        obs_ce, obs_we, obs_rmask_bad, obs_err, obs_after;
  logic [3:0]  obs_wm;
  logic [31:0] obs_wd, obs_rdata;

  task automatic sample();
    obs_ce = obs_ce | o_ce;
    if (o_we) begin
      obs_we = 1'b1;
      obs_wm = o_wmask;
      obs_wd = o_wdata;
    end
    if (o_rd && (o_rmask != 4'hF)) obs_rmask_bad = 1'b1;
  endtask

  task automatic do_op(input vec_t v);
    @(negedge clk);
    sel = v.sel; is_store = v.st; size = v.sz; sext = v.sx; addr = v.addr; wdata = v.wd;
    if (v.sel) req1 = 1'b1; else req0 = 1'b1;
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    obs_lat = 1; obs_ce = 1'b0; obs_we = 1'b0; obs_wm = '0; obs_wd = '0; obs_rmask_bad = 1'b0;
    sample();
    while (!o_done && obs_lat < 8) begin
      @(posedge clk); #1;
      obs_lat++;
      sample();
    end
    obs_rdata = o_rdata;
    obs_err   = o_err;
    @(posedge clk); #1;
    obs_after = o_done | o_busy;
  endtask

  vec_t vecs[25];

  initial begin
    vecs[0]  = '{0, 0, 2'b00, 1, 32'h13, 32'h0,        2, 0, 32'hFFFFFF88, 0, 4'h0, 32'h0};
    vecs[1]  = '{0, 0, 2'b00, 0, 32'h13, 32'h0,        2, 0, 32'h00000088, 0, 4'h0, 32'h0};
    vecs[2]  = '{0, 0, 2'b01, 1, 32'h12, 32'h0,        2, 0, 32'hFFFF8899, 0, 4'h0, 32'h0};
    vecs[3]  = '{0, 0, 2'b01, 0, 32'h10, 32'h0,        2, 0, 32'h0000AABB, 0, 4'h0, 32'h0};
    vecs[4]  = '{0, 0, 2'b00, 1, 32'h11, 32'h0,        2, 0, 32'hFFFFFFAA, 0, 4'h0, 32'h0};
    vecs[5]  = '{0, 1, 2'b00, 0, 32'h11, 32'hFFFFFFCC, 3, 0, 32'hFFFFFFAA, 1, 4'hF, 32'h8899CCBB};
    vecs[6]  = '{0, 0, 2'b10, 0, 32'h10, 32'h0,        2, 0, 32'h8899CCBB, 0, 4'h0, 32'h0};
    vecs[7]  = '{0, 1, 2'b01, 0, 32'h10, 32'hABCD1234, 2, 0, 32'h8899CCBB, 1, 4'h3, 32'hABCD1234};
    vecs[8]  = '{0, 0, 2'b10, 0, 32'h10, 32'h0,        2, 0, 32'h88991234, 0, 4'h0, 32'h0};
    vecs[9]  = '{0, 1, 2'b00, 0, 32'h10, 32'h00000055, 2, 0, 32'h88991234, 1, 4'h1, 32'h00000055};
    vecs[10] = '{0, 1, 2'b01, 0, 32'h12, 32'h00007777, 3, 0, 32'h88991234, 1, 4'hF, 32'h77771255};
    vecs[11] = '{0, 1, 2'b00, 0, 32'h13, 32'h00000001, 3, 0, 32'h88991234, 1, 4'hF, 32'h01771255};
    vecs[12] = '{0, 0, 2'b10, 0, 32'h10, 32'h0,        2, 0, 32'h01771255, 0, 4'h0, 32'h0};
    vecs[13] = '{0, 1, 2'b10, 0, 32'h14, 32'hDEADBEEF, 2, 0, 32'h01771255, 1, 4'hF, 32'hDEADBEEF};
    vecs[14] = '{0, 0, 2'b10, 0, 32'h14, 32'h0,        2, 0, 32'hDEADBEEF, 0, 4'h0, 32'h0};
    vecs[15] = '{0, 0, 2'b01, 1, 32'h16, 32'h0,        2, 0, 32'hFFFFDEAD, 0, 4'h0, 32'h0};
    vecs[16] = '{0, 0, 2'b10, 0, 32'h12, 32'h0,        1, 1, 32'hFFFFDEAD, 0, 4'h0, 32'h0};
    vecs[17] = '{0, 0, 2'b01, 1, 32'h11, 32'h0,        1, 1, 32'hFFFFDEAD, 0, 4'h0, 32'h0};
    vecs[18] = '{0, 1, 2'b10, 0, 32'h11, 32'h12345678, 1, 1, 32'hFFFFDEAD, 0, 4'h0, 32'h0};
    vecs[19] = '{0, 0, 2'b11, 0, 32'h10, 32'h0,        2, 0, 32'h01771255, 0, 4'h0, 32'h0};
    vecs[20] = '{0, 0, 2'b01, 1, 32'h12, 32'h0,        2, 0, 32'h00000177, 0, 4'h0, 32'h0};
    vecs[21] = '{1, 0, 2'b10, 0, 32'h12, 32'h0,        2, 0, 32'h8899AABB, 0, 4'h0, 32'h0};
    vecs[22] = '{1, 0, 2'b01, 0, 32'h11, 32'h0,        2, 0, 32'h0000AABB, 0, 4'h0, 32'h0};
    vecs[23] = '{1, 0, 2'b01, 1, 32'h13, 32'h0,        2, 0, 32'hFFFF8899, 0, 4'h0, 32'h0};
    vecs[24] = '{1, 1, 2'b01, 0, 32'h13, 32'h00004321, 3, 0, 32'hFFFF8899, 1, 4'hF, 32'h4321AABB};

    rst = 1'b1; mem_init = 1'b1; sel = 1'b0;
    req0 = 1'b0; req1 = 1'b0; is_store = 1'b0; size = 2'b00; sext = 1'b0;
    addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; mem_init = 1'b0;
    @(posedge clk); #1;
    check("reset busy",  o_busy,  0);
    check("reset done",  o_done,  0);
    check("reset err",   o_err,   0);
    check("reset rdata", o_rdata, 0);
    check("reset addr",  o_addr,  0);
    check("reset strobes", {o_ce, o_we, o_rd, o_wmask, o_rmask}, 0);
    check("reset wdata", o_wdata, 0);

    for (int i = 0; i < 25; i++) begin
      do_op(vecs[i]);
      check($sformatf("v%0d latency", i), obs_lat, vecs[i].lat);
      check($sformatf("v%0d err", i), obs_err, vecs[i].err);
      check($sformatf("v%0d rdata", i), obs_rdata, vecs[i].rdata);
      check($sformatf("v%0d ce_seen", i), obs_ce, !vecs[i].err);
      check($sformatf("v%0d we_seen", i), obs_we, vecs[i].we);
      if (vecs[i].we) begin
        check($sformatf("v%0d wmask", i), obs_wm, vecs[i].wm);
        check($sformatf("v%0d mem_wdata", i), obs_wd, vecs[i].wdo);
      end
      check($sformatf("v%0d rmask", i), obs_rmask_bad, 0);
      check($sformatf("v%0d single_pulse", i), obs_after, 0);
    end

    // Reset while the RMW write strobe is up: the write must never land.
    sel = 1'b0;
    @(negedge clk);
    is_store = 1'b1; size = 2'b00; sext = 1'b0; addr = 32'h11; wdata = 32'h000000EE;
    req0 = 1'b1;
    @(posedge clk); #1;
    req0 = 1'b0;
    check("rst_rmw rd", {o_busy, o_rd}, 2'b11);
    @(posedge clk); #1;
    check("rst_rmw we", o_we, 1);
    check("rst_rmw merged", o_wdata, 32'h0177EE55);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_rmw we_drop", o_we, 0);
    check("rst_rmw busy_drop", o_busy, 0);
    @(posedge clk); #1;
    check("rst_rmw no_done", o_done, 0);
    check("rst_rmw mem", mem0[4], 32'h01771255);
    check("rst_rmw rdata", o_rdata, 0);
    @(negedge clk);
    rst = 1'b0;

    // Request held across two loads: one transaction, then acceptance on the first IDLE edge.
    @(negedge clk);
    is_store = 1'b0; size = 2'b10; sext = 1'b0; addr = 32'h14; wdata = '0;
    req0 = 1'b1;
    @(posedge clk); #1;
    check("b2b s0", {o_busy, o_done}, 2'b10);
    @(posedge clk); #1;
    check("b2b s1", {o_busy, o_done}, 2'b11);
    check("b2b rdata1", o_rdata, 32'hDEADBEEF);
    @(negedge clk);
    addr = 32'h10;
    @(posedge clk); #1;
    check("b2b s2 idle", {o_busy, o_done}, 2'b00);
    @(posedge clk); #1;
    check("b2b s3 accept", {o_busy, o_done, o_ce}, 3'b101);
    @(posedge clk); #1;
    check("b2b s4", {o_busy, o_done}, 2'b11);
    check("b2b rdata2", o_rdata, 32'h01771255);
    @(negedge clk);
    req0 = 1'b0;
    @(posedge clk); #1;
    check("b2b s5", {o_busy, o_done}, 2'b00);
    @(posedge clk); #1;
    check("b2b s6", {o_busy, o_done, o_ce}, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator between the CPU's MEM stage and the data memory port. It accepts one byte, half or word load/store per request at any legal byte address. It drives the data memory's `ce`/`we`/`memRr`/mask/address/data inputs and does lane extraction and sign/zero extension for loads. Stores that cannot be expressed with the memory's low-lane write masks use a read-modify-write sequence.

## Interface
- `ALIGN_CHECK`, default 1: 1 = misaligned half/word access raises `err`; 0 = low address bits are ignored (half uses `addr[1]`, word uses `addr[31:2]`).

- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req` in 1: request strobe, sampled only in IDLE.
- `is_store` in 1: 1 = store, 0 = load.
- `size` in 2: 00 byte, 01 half, 10 word; 11 is treated as word.
- `sext` in 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `addr` in 32: byte address.
- `wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: one-cycle pulse coincident with `done` for a rejected misaligned access.
- `rdata` out 32: registered load result; holds until the next successful load.
- `mem_ce`, `mem_we`, `mem_rd` out 1 each: memory chip enable, write enable, read enable.
- `mem_addr` out 32: `{lat_addr[31:2],2'b00}`.
- `mem_wdata` out 32: memory write data.
- `mem_wmask`, `mem_rmask` out 4: memory write and read masks.
- `mem_rdata` in 32: memory read data, combinational from `mem_addr`.

## Operation
- Memory contract:
  - Read is combinational.
  - Write commits at the rising edge when `ce & we`.
  - wmask 0001 writes bits [7:0] only; 0011 writes [15:0] only; any other value writes all 32 bits.
  - The unit always reads with rmask 1111.
- States: IDLE, LOAD, WRITE, RMW_RD, RMW_WR, RESP.
- IDLE → on `req`, latch `is_store`, `size`, `sext`, `addr`, `wdata`, then:
  - misaligned and ALIGN_CHECK=1 → RESP with error flag; no memory access.
  - load → LOAD.
  - store, byte at offset 00, half at offset 00, or word → WRITE.
  - store, byte at offset 01/10/11 or half at offset 10 → RMW_RD.
- LOAD:
  - Drive ce=1, rd=1, rmask=1111.
  - Select lane by `lat_addr[1:0]` (half by `lat_addr[1]`), extend per `sext`, register into `rdata`.
  - → RESP.
- WRITE:
  - Drive ce=1, we=1, wdata=lat_wdata.
  - wmask = 0001 for byte, 0011 for half, 1111 for word.
  - → RESP.
- RMW_RD:
  - Drive ce=1, rd=1.
  - Register merged word = `mem_rdata` with the target lane(s) replaced by `lat_wdata` low bits.
  - → RMW_WR.
- RMW_WR: drive ce=1, we=1, wmask=1111, wdata=merged; → RESP.
- RESP: `done`=1, `err`=error flag; → IDLE.
- Memory strobes outside the states above: `mem_ce`/`mem_we`/`mem_rd` = 0, masks = 0000, `mem_wdata` = 0.
- A `req` seen while `busy` is ignored, not queued. The CPU holds the request until `done`, then deasserts or presents the next one.
- Stores and errored accesses leave `rdata` unchanged.

## Timing
- Reset values: state IDLE; `busy`, `done`, `err` = 0; `rdata` = 0; latched address 0, so `mem_addr` = 0; all memory strobes and masks 0.
- Reset is asynchronous. Asserting `rst` in WRITE or RMW_WR before the rising edge drops `mem_we` immediately, so that write never commits.
- Latency, counted as edges from the accepting edge to the `done` cycle:
  - load: 2
  - direct store: 2
  - RMW store: 3
  - error: 1
- Back-to-back: a `req` held in the IDLE cycle right after RESP is accepted. Minimum spacing between accepted requests is 3 cycles for load/direct store and 4 for RMW.
- `rdata` becomes valid in the same cycle `done` rises.

## Test plan
- Preload word 0x10 = 0x8899AABB.
  - LB 0x13, sext=1 → `rdata`=0xFFFFFF88, `done` 2 cycles after accept.
  - LBU 0x13 → 0x00000088.
  - LH 0x12, sext=1 → 0xFFFF8899.
  - LHU 0x10 → 0x0000AABB.
- SB 0x11, wdata 0xCC → RMW_RD cycle, then RMW_WR cycle with `mem_wdata`=0x8899CCBB and wmask 1111. `done` 3 cycles after accept; a following LW 0x10 returns 0x8899CCBB.
- SH 0x10, wdata 0x00001234 → a single WRITE cycle with wmask 0011; LW 0x10 returns 0x88991234. SB 0x10, wdata 0x55 → wmask 0001.
- LW 0x12 with ALIGN_CHECK=1 → `done`=`err`=1 one cycle after accept; `mem_ce` never rises; `rdata` unchanged. With ALIGN_CHECK=0 → reads word 0x10.
- Assert `rst` mid-cycle during RMW_WR → `busy`/`mem_we` go low immediately, no `done`; word 0x10 is unchanged.
- Hold `req` high across a load → exactly one transaction until the cycle after `done`. Then a second load is accepted on the first IDLE edge.
